dmem_responder: RTL and testbench
=================================

# dmem_responder

Tagged data-memory responder: the memory-side end of the dcache bus protocol. It accepts one BUS_LOAD/BUS_STORE per cycle and returns a nonzero 4-bit transaction tag in the same cycle, or 0 if it refuses the command. After a programmable latency it broadcasts each tag with its data. It backs a word-addressed 64-bit storage array and is the block the dcache command queue talks to in system simulation.

## Interface
- MEM_WORDS, 1024, number of 64-bit words in storage; must be a power of two.
- LATENCY, 10, cycles from acceptance to earliest completion; must be at least 1.
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- proc2Dmem_command  in  2  0 = BUS_NONE, 1 = BUS_LOAD, 2 = BUS_STORE; 3 is treated as BUS_NONE.
- proc2Dmem_addr  in  64  byte address. Word index is addr[3 +: log2(MEM_WORDS)]. addr[2:0] and the bits above the index are ignored.
- proc2Dmem_data  in  64  store data.
- mem_stall  in  1  when 1, no command is accepted this cycle (backpressure injection).
- Dmem2proc_response  out  4  combinational; tag assigned to this cycle's command, 0 = not accepted.
- Dmem2proc_data  out  64  registered; data for the completing tag (0 when tag is 0).
- Dmem2proc_tag  out  4  registered; completing tag, 0 = no completion this cycle.

## Operation
- Tag pool: tags 1..15, each with a state FREE, PENDING(timer), or READY, plus a latched 64-bit payload.
- Accept condition: command is LOAD or STORE, mem_stall is 0, and at least one tag is FREE.
  - Dmem2proc_response is the lowest-numbered FREE tag. Otherwise it is 0.
- On accept of a LOAD: read storage[index] in the same cycle, latch it into the tag payload, and set the tag to PENDING.
- On accept of a STORE: write storage[index] at the clock edge, latch the store data as payload, and set the tag to PENDING. Stores complete on the tag bus like loads.
- Ordering follows acceptance order. A load accepted in the cycle after a store to the same word returns the stored value. A load and a store can never be accepted in the same cycle.
- Timer: a tag loaded at acceptance in cycle T becomes eligible to complete in cycle T+LATENCY (PENDING → READY).
- Completion arbiter: each cycle, the lowest-numbered READY tag (including tags becoming READY this cycle) is driven on Dmem2proc_tag/Dmem2proc_data. That tag returns to FREE. Other READY tags wait with no loss.
- A tag freed by completion in cycle C is not reissuable until cycle C+1.
- Storage is not cleared by reset. Contents are X until written.
- Reset, including mid-operation: all tags become FREE, the timers are discarded, and no completion of a pre-reset tag ever appears. Dmem2proc_tag = 0, Dmem2proc_data = 0, and Dmem2proc_response = 0 while reset is high.

## Timing
- Response latency is 0 cycles (combinational from command, mem_stall and tag states).
- Minimum completion latency is exactly LATENCY cycles after the accept cycle. It is longer only under arbiter contention: the k-th of simultaneously ready tags completes k-1 cycles late.
- Throughput is one accept and one completion per cycle sustained. With 15 outstanding and none completing, response is 0.
- Simultaneous accept and completion in one cycle is legal. The accepted tag is never the completing tag.
- Outputs after reset: Dmem2proc_tag = 0, Dmem2proc_data = 0, Dmem2proc_response = 0 until the first legal command.

## Structure
- Shared package mem_pkg: BUS_NONE/BUS_LOAD/BUS_STORE encodings, TAG_W = 4, NUM_TAGS = 15, tag-state enum {FREE, PENDING, READY}. The dcache uses the same package.
- Sub-module pri_enc16: 16-bit lowest-set-bit priority encoder with a valid flag. It is instantiated twice: free-tag select (bit 0 masked) and ready-tag select.
- Timers are per-tag down-counters of width clog2(LATENCY+1). Storage is a single reg array in the top module.

## Test plan
- Store 0xDEADBEEF_00000001 to addr 0x40 in cycle 0 (response 1), then load addr 0x40 in cycle 1 (response 2). Required: tag 1 at cycle 10 with data equal to the store data, and tag 2 at cycle 11 with data 0xDEADBEEF_00000001.
- Issue 15 back-to-back loads. Required: responses 1..15, the 16th command gets response 0, and with LATENCY=10 completions are tags 1..15 in cycles 10..24.
- Issue a load with mem_stall=1, then the same load with mem_stall=0. Required: response 0, then response 1, and completion exactly LATENCY cycles after the second command.
- Fill all tags. In the cycle tag 1 completes, issue a load. Required: response 0 that cycle and response 1 in the next cycle.
- Issue loads at addr 0x8 and addr 0x8 + 8*MEM_WORDS after a store to 0x8. Required: both return the stored value (aliasing).
- Assert reset for 1 cycle with 5 tags pending. Required: no nonzero Dmem2proc_tag in the 2*LATENCY cycles after reset, and the next accepted load gets response 1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared dcache/memory bus definitions: command encodings, tag sizing and tag-pool states.
package mem_pkg;

  localparam int unsigned TAG_W    = 4;
  localparam int unsigned NUM_TAGS = 15;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    READY   = 2'd2
  } tag_state_e;

endpackage

// File: rtl/pri_enc16.sv
// Lowest-set-bit priority encoder over 16 requests, with a valid flag.
module pri_enc16 (
  input  logic [15:0] req_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = 4'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Tagged data-memory responder: issues transaction tags on accept and
// broadcasts each tag with its data after a programmable latency.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [63:0] proc2Dmem_addr,
  input  logic [63:0] proc2Dmem_data,
  input  logic        mem_stall,
  output logic [3:0]  Dmem2proc_response,
  output logic [63:0] Dmem2proc_data,
  output logic [3:0]  Dmem2proc_tag
);

  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned TMR_W  = $clog2(LATENCY + 1);
  localparam bit          BYPASS = (LATENCY == 1);

  logic [63:0]      mem [MEM_WORDS];
  tag_state_e       state_q   [1:NUM_TAGS];
  tag_state_e       state_d   [1:NUM_TAGS];
  logic [TMR_W-1:0] timer_q   [1:NUM_TAGS];
  logic [TMR_W-1:0] timer_d   [1:NUM_TAGS];
  logic [63:0]      payload_q [1:NUM_TAGS];
  logic [63:0]      payload_d [1:NUM_TAGS];
  logic [TAG_W-1:0] comp_tag_q, comp_tag_d;
  logic [63:0]      comp_data_q, comp_data_d;

  logic [IDX_W-1:0] word_idx;
  logic             is_load, is_store, accept;
  logic [63:0]      acc_payload;
  logic [15:0]      free_vec, elig_vec;
  logic [TAG_W-1:0] free_idx, rdy_idx;
  logic             free_valid, rdy_valid;
  logic             unused_addr_bits;

  assign word_idx         = proc2Dmem_addr[3 +: IDX_W];
  assign unused_addr_bits = ^{proc2Dmem_addr[2:0], proc2Dmem_addr[63:3+IDX_W]};
  assign is_load          = (proc2Dmem_command == BUS_LOAD);
  assign is_store         = (proc2Dmem_command == BUS_STORE);
  assign accept           = (is_load | is_store) & ~mem_stall & ~reset & free_valid;
  assign acc_payload      = is_store ? proc2Dmem_data : mem[word_idx];

  always_comb begin
    free_vec = '0;
    for (int i = 1; i <= NUM_TAGS; i++) free_vec[i] = (state_q[i] == FREE);
  end

  // The tag on the bus this cycle stays READY until the edge, so it is masked out.
  always_comb begin
    elig_vec = '0;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      elig_vec[i] = (state_q[i] == READY && comp_tag_q != TAG_W'(i))
                 || (state_q[i] == PENDING && timer_q[i] == TMR_W'(1))
                 || (BYPASS && accept && free_idx == TAG_W'(i));
    end
  end

  pri_enc16 u_free_enc (
    .req_i   (free_vec),
    .idx_o   (free_idx),
    .valid_o (free_valid)
  );

  pri_enc16 u_rdy_enc (
    .req_i   (elig_vec),
    .idx_o   (rdy_idx),
    .valid_o (rdy_valid)
  );

  always_comb begin
    for (int i = 1; i <= NUM_TAGS; i++) begin
      state_d[i]   = state_q[i];
      timer_d[i]   = timer_q[i];
      payload_d[i] = payload_q[i];
      if (accept && free_idx == TAG_W'(i)) begin
        state_d[i]   = BYPASS ? READY : PENDING;
        timer_d[i]   = TMR_W'(LATENCY - 1);
        payload_d[i] = acc_payload;
      end else if (comp_tag_q == TAG_W'(i)) begin
        state_d[i] = FREE;
      end else if (state_q[i] == PENDING) begin
        if (timer_q[i] == TMR_W'(1)) state_d[i] = READY;
        else                         timer_d[i] = TMR_W'(timer_q[i] - TMR_W'(1));
      end
    end
  end

  // Completion select; a single-cycle latency forwards the accepting payload directly.
  always_comb begin
    comp_tag_d  = rdy_valid ? rdy_idx : '0;
    comp_data_d = '0;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      if (rdy_valid && rdy_idx == TAG_W'(i)) comp_data_d = payload_q[i];
    end
    if (BYPASS && accept && rdy_valid && rdy_idx == free_idx) comp_data_d = acc_payload;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i <= NUM_TAGS; i++) begin
        state_q[i] <= FREE;
        timer_q[i] <= '0;
      end
      comp_tag_q  <= '0;
      comp_data_q <= '0;
    end else begin
      for (int i = 1; i <= NUM_TAGS; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      comp_tag_q  <= comp_tag_d;
      comp_data_q <= comp_data_d;
    end
  end

  // Payloads and storage are data-only and survive reset.
  always_ff @(posedge clock) begin
    for (int i = 1; i <= NUM_TAGS; i++) payload_q[i] <= payload_d[i];
    if (accept && is_store) mem[word_idx] <= proc2Dmem_data;
  end

  assign Dmem2proc_response = accept ? free_idx : '0;
  assign Dmem2proc_tag      = reset ? '0 : comp_tag_q;
  assign Dmem2proc_data     = reset ? '0 : comp_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic, all checked
// cycle by cycle against a tag-pool/memory reference model.
module tb_dmem_responder;
  import mem_pkg::*;

  localparam int unsigned LAT   = 16;
  localparam int unsigned WORDS = 64;

  logic        clock;
  logic        reset;
  logic [1:0]  proc2Dmem_command;
  logic [63:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  logic        mem_stall;
  logic [3:0]  Dmem2proc_response;
  logic [63:0] Dmem2proc_data;
  logic [3:0]  Dmem2proc_tag;

  dmem_responder #(.MEM_WORDS(WORDS), .LATENCY(LAT)) dut (
    .clock              (clock),
    .reset              (reset),
    .proc2Dmem_command  (proc2Dmem_command),
    .proc2Dmem_addr     (proc2Dmem_addr),
    .proc2Dmem_data     (proc2Dmem_data),
    .mem_stall          (mem_stall),
    .Dmem2proc_response (Dmem2proc_response),
    .Dmem2proc_data     (Dmem2proc_data),
    .Dmem2proc_tag      (Dmem2proc_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int now   = 0;

  // Model: a tag is outstanding from accept until it completes; a completed tag
  // is held for its completion cycle and free from the next one.
  bit          m_out  [16];
  bit          m_hold [16];
  int          m_acc  [16];
  logic [63:0] m_pay  [16];
  logic [63:0] m_mem  [WORDS];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", name, obs, exp, now);
    end
  endtask

  task automatic cyc(input logic rst, input logic [1:0] cmd, input logic [63:0] addr,
                     input logic [63:0] wd, input logic stall, output logic [3:0] resp);
    int          et, er, w;
    logic [63:0] ed;
    et = 0; er = 0; ed = '0;
    w  = int'((addr >> 3) % 64'(WORDS));
    for (int i = 1; i < 16; i++) m_hold[i] = 1'b0;
    if (rst) begin
      for (int i = 1; i < 16; i++) m_out[i] = 1'b0;
    end else begin
      for (int i = 1; i < 16; i++) begin
        if (et == 0 && m_out[i] && m_acc[i] + int'(LAT) <= now) begin
          et = i; ed = m_pay[i]; m_out[i] = 1'b0; m_hold[i] = 1'b1;
        end
      end
      if ((cmd == 2'd1 || cmd == 2'd2) && !stall) begin
        for (int i = 1; i < 16; i++) if (er == 0 && !m_out[i] && !m_hold[i]) er = i;
      end
      if (er != 0) begin
        m_out[er] = 1'b1;
        m_acc[er] = now;
        m_pay[er] = (cmd == 2'd2) ? wd : m_mem[w];
        if (cmd == 2'd2) m_mem[w] = wd;
      end
    end
    reset = rst; proc2Dmem_command = cmd; proc2Dmem_addr = addr;
    proc2Dmem_data = wd; mem_stall = stall;
    #1;
    resp = Dmem2proc_response;
    check("response", 64'(resp), 64'(er));
    check("tag", 64'(Dmem2proc_tag), 64'(et));
    check("data", Dmem2proc_data, ed);
    @(posedge clock); #1;
    now++;
  endtask

  task automatic idle(input int n);
    logic [3:0] r;
    for (int i = 0; i < n; i++) cyc(1'b0, BUS_NONE, '0, '0, 1'b0, r);
  endtask

  initial begin
    logic [3:0]  r;
    logic [63:0] d;
    int          tries;
    int          fill_exp [18];

    reset = 1'b1; proc2Dmem_command = '0; proc2Dmem_addr = '0;
    proc2Dmem_data = '0; mem_stall = 1'b0;
    @(posedge clock); #1;
    cyc(1'b1, BUS_NONE, '0, '0, 1'b0, r);
    cyc(1'b1, BUS_LOAD, 64'h40, '0, 1'b0, r);
    check("resp_in_reset", 64'(r), 64'd0);

    // Store then load to the same word.
    cyc(1'b0, BUS_STORE, 64'h40, 64'hDEADBEEF_00000001, 1'b0, r);
    check("t1_store_resp", 64'(r), 64'd1);
    cyc(1'b0, BUS_LOAD, 64'h40, '0, 1'b0, r);
    check("t1_load_resp", 64'(r), 64'd2);
    idle(LAT + 4);

    // Give every word a known value.
    for (int w = 0; w < int'(WORDS); w++) begin
      tries = 0;
      d = {$urandom, $urandom};
      do begin
        cyc(1'b0, BUS_STORE, 64'(w * 8), d, 1'b0, r);
        tries++;
      end while (r == 0 && tries < 40);
      if (r == 0) check("init_store_accepted", 64'(r), 64'd1);
    end
    idle(LAT + 20);

    // Back-to-back loads: fill the pool, then retry across tag 1's completion.
    for (int k = 0; k < 15; k++) fill_exp[k] = k + 1;
    fill_exp[15] = 0; fill_exp[16] = 0; fill_exp[17] = 1;
    for (int k = 0; k < 18; k++) begin
      cyc(1'b0, BUS_LOAD, 64'(k * 8), '0, 1'b0, r);
      check("fill_resp", 64'(r), 64'(fill_exp[k]));
    end
    idle(LAT + 20);

    // Backpressure.
    cyc(1'b0, BUS_LOAD, 64'h18, '0, 1'b1, r);
    check("stall_resp", 64'(r), 64'd0);
    cyc(1'b0, BUS_LOAD, 64'h18, '0, 1'b0, r);
    check("unstall_resp", 64'(r), 64'd1);
    idle(LAT + 3);

    // Address aliasing above the word index.
    cyc(1'b0, BUS_STORE, 64'h8, 64'h0123_4567_89AB_CDEF, 1'b0, r);
    cyc(1'b0, BUS_LOAD, 64'h8, '0, 1'b0, r);
    cyc(1'b0, BUS_LOAD, 64'h8 + 64'(8 * WORDS), '0, 1'b0, r);
    idle(LAT + 3);

    // Random traffic with occasional reset.
    for (int k = 0; k < 500; k++) begin
      cyc(($urandom_range(0, 149) == 0), 2'($urandom_range(0, 3)), {$urandom, $urandom},
          {$urandom, $urandom}, ($urandom_range(0, 7) == 0), r);
    end
    idle(LAT + 20);

    // Reset with five tags pending.
    for (int k = 0; k < 5; k++) cyc(1'b0, BUS_LOAD, 64'(k * 8), '0, 1'b0, r);
    cyc(1'b1, BUS_NONE, '0, '0, 1'b0, r);
    idle(2 * LAT);
    cyc(1'b0, BUS_LOAD, 64'h20, '0, 1'b0, r);
    check("post_reset_resp", 64'(r), 64'd1);
    idle(LAT + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
